sign_compress_unit: RTL and testbench

// - Inverse of the 9-bit -> 16-bit sign-extension path: narrows 16-bit ALU/register words to the 9-bit immediate format.
// - 9-bit format: bit 8 = sign, bits 7:0 = low byte. Expansion is {8{bit8}, bits7:0}.
// - Checks that each word survives the round trip. Buffers results in a 2-entry output queue and counts overflows.
// - Sits between the datapath result bus and the immediate/operand store of the calculator processor.

---
 rtl/sign_compress_unit.sv | 141 ++++++++++++++
 tb/tb_sign_compress_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sign_compress_unit.sv
// Narrows DATA_W-bit words to the IMM_W-bit sign+low-bits immediate format behind a 2-entry FIFO.
// Define SCU_SATURATE_EN to clamp non-representable words instead of truncating them.
module sign_compress_unit #(
   parameter int DATA_W = 16,
   parameter int IMM_W  = 9,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IMM_W-1:0]  out_data,
   output logic              out_ovf,
   output logic              ovf_sticky,
   output logic [CNT_W-1:0]  ovf_count,
   input  logic              clr_ovf
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam int UP_W = DATA_W - IMM_W + 1;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [IMM_W-1:0] tail_data;
   logic             tail_ovf;
   logic             push;
   logic             pop;
   logic [UP_W-1:0]  upper;
   logic             repr;
   logic [IMM_W-1:0] narrow_data;

   // A word fits when every bit from the narrowed sign position upward agrees.
   function automatic logic fits(input logic [UP_W-1:0] u);
      return (&u) | ~(|u);
   endfunction

   assign push  = in_valid & in_ready;
   assign pop   = out_valid & out_ready;
   assign upper = in_data[DATA_W-1:IMM_W-1];
   assign repr  = fits(upper);

   // Narrowed value of the incoming word
   always_comb begin
      narrow_data = {in_data[DATA_W-1], in_data[IMM_W-2:0]};
      if (repr) begin
         narrow_data = {in_data[DATA_W-1], in_data[IMM_W-2:0]};
      end else begin
`ifdef SCU_SATURATE_EN
         narrow_data = in_data[DATA_W-1] ? {1'b1, {(IMM_W-1){1'b0}}}
                                         : {1'b0, {(IMM_W-1){1'b1}}};
`else
         narrow_data = {in_data[DATA_W-1], in_data[IMM_W-2:0]};
`endif
      end
   end

   // Occupancy next-state
   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: begin
            if (push) state_next = ST_ONE;
            else      state_next = ST_EMPTY;
         end
         ST_ONE: begin
            if (push && !pop)      state_next = ST_TWO;
            else if (!push && pop) state_next = ST_EMPTY;
            else                   state_next = ST_ONE;
         end
         ST_TWO: begin
            if (pop) state_next = ST_ONE;
            else     state_next = ST_TWO;
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // Queue storage; handshake flags are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= {IMM_W{1'b0}};
         out_ovf   <= 1'b0;
         tail_data <= {IMM_W{1'b0}};
         tail_ovf  <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next != ST_TWO);
         out_valid <= (state_next != ST_EMPTY);
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  out_data <= narrow_data;
                  out_ovf  <= ~repr;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  out_data <= narrow_data;
                  out_ovf  <= ~repr;
               end else if (push) begin
                  tail_data <= narrow_data;
                  tail_ovf  <= ~repr;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  out_data <= tail_data;
                  out_ovf  <= tail_ovf;
               end
            end
            default: begin
               out_data <= {IMM_W{1'b0}};
               out_ovf  <= 1'b0;
            end
         endcase
      end
   end

   // Overflow statistics; a clear beats a simultaneous overflowing push
   always_ff @(posedge clk) begin
      if (rst || clr_ovf) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= {CNT_W{1'b0}};
      end else if (push && !repr) begin
         ovf_sticky <= 1'b1;
         if (!(&ovf_count)) begin
            ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_sign_compress_unit.sv
// Self-checking bench for sign_compress_unit: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model (honours SCU_SATURATE_EN).
module tb_sign_compress_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [8:0]  out_data;
   logic        out_ovf;
   logic        ovf_sticky;
   logic [7:0]  ovf_count;
   logic        clr_ovf = 1'b0;

   int n_total = 0;
   int n_pass  = 0;

   logic [9:0] mq[$];
   int         m_count = 0;
   logic       m_sticky = 1'b0;

   typedef struct {
      logic [15:0] din;
      logic [8:0]  dout;
      logic        ovf;
   } vec_t;
   vec_t vecs[6];

   sign_compress_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
      .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference narrowing from signed value range; returns {ovf, data}
   function automatic logic [9:0] ref_narrow(input logic [15:0] d);
      int v;
      logic [8:0] r;
      logic ovf;
      v = int'($signed(d));
      ovf = (v < -256) || (v > 255);
      if (!ovf) r = 9'(v & 511);
`ifdef SCU_SATURATE_EN
      else r = (v < 0) ? 9'h100 : 9'h0FF;
`else
      else r = {d[15], d[7:0]};
`endif
      return {ovf, r};
   endfunction

   // Entered at posedge+1; checks outputs against the model, applies one clock.
   task automatic cycle(input logic v, input logic [15:0] d, input logic r, input logic c);
      logic do_push, do_pop;
      logic [9:0] nw;
      in_valid = v; in_data = d; out_ready = r; clr_ovf = c;
      #3;
      chk("q_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("q_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (mq.size() != 0) begin
         chk("q_data", {23'd0, out_data}, {23'd0, mq[0][8:0]});
         chk("q_ovf", {31'd0, out_ovf}, {31'd0, mq[0][9]});
      end
      chk("ovf_cnt", {24'd0, ovf_count}, 32'(m_count));
      chk("ovf_stk", {31'd0, ovf_sticky}, {31'd0, m_sticky});
      do_push = v && (mq.size() < 2);
      do_pop  = r && (mq.size() > 0);
      nw = ref_narrow(d);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(nw);
      if (c) begin
         m_count = 0; m_sticky = 1'b0;
      end else if (do_push && nw[9]) begin
         m_sticky = 1'b1;
         if (m_count < 255) m_count++;
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      #3;
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_data"}, {23'd0, out_data}, 32'd0);
      chk({tag, "_ovf"}, {31'd0, out_ovf}, 32'd0);
      chk({tag, "_stk"}, {31'd0, ovf_sticky}, 32'd0);
      chk({tag, "_cnt"}, {24'd0, ovf_count}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0] = '{16'h007F, 9'h07F, 1'b0};
      vecs[1] = '{16'hFF80, 9'h180, 1'b0};
      vecs[2] = '{16'hFF00, 9'h100, 1'b0};
      vecs[3] = '{16'h0000, 9'h000, 1'b0};
`ifdef SCU_SATURATE_EN
      vecs[4] = '{16'h0100, 9'h0FF, 1'b1};
`else
      vecs[4] = '{16'h0100, 9'h000, 1'b1};
`endif
      vecs[5] = '{16'h8000, 9'h100, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("rst0");

      // Directed vectors: push into empty queue, compare head, pop
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, vecs[i].din, 1'b0, 1'b0);
         chk("vec_data", {23'd0, out_data}, {23'd0, vecs[i].dout});
         chk("vec_ovf", {31'd0, out_ovf}, {31'd0, vecs[i].ovf});
         cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      end
      chk("vec_cnt", {24'd0, ovf_count}, 32'd2);
      chk("vec_stk", {31'd0, ovf_sticky}, 32'd1);

      // Backpressure
      cycle(1'b1, 16'h0001, 1'b0, 1'b0);
      cycle(1'b1, 16'h0002, 1'b0, 1'b0);
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      cycle(1'b1, 16'h0003, 1'b0, 1'b0);
      cycle(1'b1, 16'h0003, 1'b1, 1'b0);
      cycle(1'b1, 16'h0003, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Streaming
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 16'(i), 1'b1, 1'b0);
         chk("stream_rdy", {31'd0, in_ready}, 32'd1);
      end
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);

      // Counter saturation and clear
      for (int i = 0; i < 300; i++) cycle(1'b1, 16'h1234, 1'b1, 1'b0);
      chk("cnt_sat", {24'd0, ovf_count}, 32'd255);
      cycle(1'b1, 16'h1234, 1'b1, 1'b1);
      chk("clr_cnt", {24'd0, ovf_count}, 32'd0);
      chk("clr_stk", {31'd0, ovf_sticky}, 32'd0);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if ($urandom_range(0, 1) == 0) d = {{8{d[15]}}, d[7:0]};
         cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 30) == 0));
      end

      // Reset with two words queued
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      cycle(1'b1, 16'h0100, 1'b0, 1'b0);
      cycle(1'b1, 16'h0005, 1'b0, 1'b0);
      chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete(); m_count = 0; m_sticky = 1'b0;
      check_reset_outputs("rst1");
      mq.delete();
      in_valid = 1'b1; in_data = 16'h0042;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_push_v", {31'd0, out_valid}, 32'd1);
      chk("post_rst_push_d", {23'd0, out_data}, 32'h042);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
